counter_disable_delay: RTL and testbench

COUNTER_DISABLE_DELAY -- requirements
Module: counter_disable_delay

---
 rtl/counter_disable_delay.sv | 159 +++++++++++++++
 tb/tb_counter_disable_delay.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/counter_disable_delay.sv
// -----------------------------------------------------------------------------
// counter_disable_delay
//
// Purpose:
//   Passes a raw enable through to a registered output. The rising edge
//   appears one clock later. The falling edge is stretched by a programmable
//   number of clock cycles. The hold length is sampled from `delay` while
//   enable is high. Once a countdown starts, that value is frozen, so later
//   changes on `delay` cannot shorten or extend a running hold.
//
// Parameters:
//   COUNTER_WIDTH  width of the delay input and of the internal hold counter.
//
// Ports:
//   clock           single rising-edge clock
//   reset           synchronous, active-high reset
//   enable          raw enable whose falling edge is delayed
//   delay           hold time in clock cycles (unsigned)
//   delayed_enable  registered enable with a delayed falling edge
//   hold_active     high while the hold countdown runs (state HOLD)
//   hold_done       one-cycle pulse when delayed_enable falls because
//                   enable dropped (not on reset, not on re-assert)
//   count_out       remaining hold count, 0 outside HOLD
// -----------------------------------------------------------------------------
module counter_disable_delay #(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [COUNTER_WIDTH-1:0] delay,
  output logic                     delayed_enable,
  output logic                     hold_active,
  output logic                     hold_done,
  output logic [COUNTER_WIDTH-1:0] count_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1'b1);

  // Registered state and outputs
  state_t                     state_r;
  logic [COUNTER_WIDTH-1:0]   latched_delay_r;
  logic [COUNTER_WIDTH-1:0]   counter_r;
  logic                       delayed_enable_r;
  logic                       hold_active_r;
  logic                       hold_done_r;

  // Next-state values
  state_t                     state_s;
  logic [COUNTER_WIDTH-1:0]   latched_delay_s;
  logic [COUNTER_WIDTH-1:0]   counter_s;
  logic                       delayed_enable_s;
  logic                       hold_done_s;

  // Next-state and next-output decode for the IDLE/ON/HOLD machine
  always_comb begin
    state_s          = state_r;
    latched_delay_s  = latched_delay_r;
    counter_s        = counter_r;
    delayed_enable_s = delayed_enable_r;
    hold_done_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (enable) begin
          state_s          = ON;
          latched_delay_s  = delay;
          delayed_enable_s = 1'b1;
          counter_s        = CNT_ZERO;
        end else begin
          state_s          = IDLE;
          delayed_enable_s = 1'b0;
          counter_s        = CNT_ZERO;
        end
      end

      ON: begin
        if (enable) begin
          // Keep tracking delay so that the value present at the fall is used.
          state_s          = ON;
          latched_delay_s  = delay;
          delayed_enable_s = 1'b1;
          counter_s        = CNT_ZERO;
        end else if (latched_delay_r == CNT_ZERO) begin
          // Zero hold: the output falls at the same edge as the plain path.
          state_s          = IDLE;
          delayed_enable_s = 1'b0;
          counter_s        = CNT_ZERO;
          hold_done_s      = 1'b1;
        end else begin
          state_s          = HOLD;
          delayed_enable_s = 1'b1;
          counter_s        = latched_delay_r;
        end
      end

      HOLD: begin
        if (enable) begin
          // Re-assert during hold: return to ON without a gap or a done pulse.
          state_s          = ON;
          latched_delay_s  = delay;
          delayed_enable_s = 1'b1;
          counter_s        = CNT_ZERO;
        end else if (counter_r > CNT_ONE) begin
          state_s          = HOLD;
          delayed_enable_s = 1'b1;
          counter_s        = counter_r - CNT_ONE;
        end else begin
          // Last hold cycle. A counter of 0 cannot occur in HOLD. If it is
          // seen anyway, finish the hold here instead of wrapping to all-ones.
          state_s          = IDLE;
          delayed_enable_s = 1'b0;
          counter_s        = CNT_ZERO;
          hold_done_s      = 1'b1;
        end
      end

      default: begin
        state_s          = IDLE;
        latched_delay_s  = CNT_ZERO;
        delayed_enable_s = 1'b0;
        counter_s        = CNT_ZERO;
        hold_done_s      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r          <= IDLE;
      latched_delay_r  <= CNT_ZERO;
      counter_r        <= CNT_ZERO;
      delayed_enable_r <= 1'b0;
      hold_active_r    <= 1'b0;
      hold_done_r      <= 1'b0;
    end else begin
      state_r          <= state_s;
      latched_delay_r  <= latched_delay_s;
      counter_r        <= counter_s;
      delayed_enable_r <= delayed_enable_s;
      hold_active_r    <= (state_s == HOLD);
      hold_done_r      <= hold_done_s;
    end
  end

  assign delayed_enable = delayed_enable_r;
  assign hold_active    = hold_active_r;
  assign hold_done      = hold_done_r;
  assign count_out      = counter_r;

endmodule

// File: tb/tb_counter_disable_delay.sv
// -----------------------------------------------------------------------------
// tb_counter_disable_delay
//
// Directed bench for counter_disable_delay. It uses two instances that share
// clock, reset and enable:
//   dut     default COUNTER_WIDTH (16)
//   dut_w4  COUNTER_WIDTH = 4, used to exercise the maximum-delay case
// Outputs are sampled 1 time unit after each rising edge. Inputs are then
// driven for the next edge.
// -----------------------------------------------------------------------------
module tb_counter_disable_delay;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [15:0] delay;
  logic        delayed_enable;
  logic        hold_active;
  logic        hold_done;
  logic [15:0] count_out;

  logic [3:0]  delay_w4;
  logic        de_w4;
  logic        ha_w4;
  logic        hd_w4;
  logic [3:0]  cnt_w4;

  logic        hd_prev;
  int          n_checks;
  int          n_fail;

  assign delay_w4 = delay[3:0];

  counter_disable_delay dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .delay          (delay),
    .delayed_enable (delayed_enable),
    .hold_active    (hold_active),
    .hold_done      (hold_done),
    .count_out      (count_out)
  );

  counter_disable_delay #(.COUNTER_WIDTH(4)) dut_w4 (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .delay          (delay_w4),
    .delayed_enable (de_w4),
    .hold_active    (ha_w4),
    .hold_done      (hd_w4),
    .count_out      (cnt_w4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, then compare all main-DUT outputs with expectations.
  task automatic step_chk(input string tag, input logic exp_de, input logic exp_ha,
                          input logic exp_hd, input logic [15:0] exp_cnt);
    @(posedge clock);
    #1;
    check_eq({tag, "_de"},  32'(delayed_enable), 32'(exp_de));
    check_eq({tag, "_ha"},  32'(hold_active),    32'(exp_ha));
    check_eq({tag, "_hd"},  32'(hold_done),      32'(exp_hd));
    check_eq({tag, "_cnt"}, 32'(count_out),      32'(exp_cnt));
    check_eq({tag, "_hd_twice"}, 32'(hold_done & hd_prev), 32'd0);
    hd_prev = hold_done;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    hd_prev  = 1'b0;
    reset    = 1'b1;
    enable   = 1'b1;
    delay    = 16'd5;

    // Reset wins over enable=1.
    step_chk("rst_en", 1'b0, 1'b0, 1'b0, 16'd0);
    enable = 1'b0;
    step_chk("rst", 1'b0, 1'b0, 1'b0, 16'd0);

    // Zero delay: output follows enable with 1-cycle lag, done at the fall.
    reset  = 1'b0;
    delay  = 16'd0;
    enable = 1'b1;
    repeat (5) step_chk("zd_on", 1'b1, 1'b0, 1'b0, 16'd0);
    enable = 1'b0;
    step_chk("zd_fall", 1'b0, 1'b0, 1'b1, 16'd0);
    step_chk("zd_idle", 1'b0, 1'b0, 1'b0, 16'd0);

    // Nominal hold of 4 cycles.
    delay  = 16'd4;
    enable = 1'b1;
    repeat (3) step_chk("nom_on", 1'b1, 1'b0, 1'b0, 16'd0);
    enable = 1'b0;
    step_chk("nom_h4", 1'b1, 1'b1, 1'b0, 16'd4);
    step_chk("nom_h3", 1'b1, 1'b1, 1'b0, 16'd3);
    step_chk("nom_h2", 1'b1, 1'b1, 1'b0, 16'd2);
    step_chk("nom_h1", 1'b1, 1'b1, 1'b0, 16'd1);
    step_chk("nom_fall", 1'b0, 1'b0, 1'b1, 16'd0);
    step_chk("nom_idle", 1'b0, 1'b0, 1'b0, 16'd0);

    // Re-assert during hold: no gap, no done, counter cleared, delay re-latched.
    delay  = 16'd10;
    enable = 1'b1;
    repeat (2) step_chk("ra_on", 1'b1, 1'b0, 1'b0, 16'd0);
    enable = 1'b0;
    step_chk("ra_h10", 1'b1, 1'b1, 1'b0, 16'd10);
    step_chk("ra_h9",  1'b1, 1'b1, 1'b0, 16'd9);
    step_chk("ra_h8",  1'b1, 1'b1, 1'b0, 16'd8);
    enable = 1'b1;
    step_chk("ra_back", 1'b1, 1'b0, 1'b0, 16'd0);
    delay = 16'd0;
    step_chk("ra_relatch", 1'b1, 1'b0, 1'b0, 16'd0);
    enable = 1'b0;
    step_chk("ra_fall0", 1'b0, 1'b0, 1'b1, 16'd0);

    // Delay change during hold is ignored; next enable-high edge latches it.
    delay  = 16'd6;
    enable = 1'b1;
    step_chk("dc_on", 1'b1, 1'b0, 1'b0, 16'd0);
    enable = 1'b0;
    step_chk("dc_h6", 1'b1, 1'b1, 1'b0, 16'd6);
    delay = 16'd2;
    for (int i = 5; i >= 1; i--) step_chk("dc_hold", 1'b1, 1'b1, 1'b0, 16'(i));
    step_chk("dc_fall", 1'b0, 1'b0, 1'b1, 16'd0);
    enable = 1'b1;
    step_chk("dc_on2", 1'b1, 1'b0, 1'b0, 16'd0);
    enable = 1'b0;
    step_chk("dc_h2", 1'b1, 1'b1, 1'b0, 16'd2);
    step_chk("dc_h1", 1'b1, 1'b1, 1'b0, 16'd1);
    step_chk("dc_fall2", 1'b0, 1'b0, 1'b1, 16'd0);

    // Reset 3 cycles into a hold of 8: abort without done.
    delay  = 16'd8;
    enable = 1'b1;
    step_chk("rh_on", 1'b1, 1'b0, 1'b0, 16'd0);
    enable = 1'b0;
    step_chk("rh_h8", 1'b1, 1'b1, 1'b0, 16'd8);
    step_chk("rh_h7", 1'b1, 1'b1, 1'b0, 16'd7);
    step_chk("rh_h6", 1'b1, 1'b1, 1'b0, 16'd6);
    reset  = 1'b1;
    enable = 1'b1;
    step_chk("rh_rst", 1'b0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    step_chk("rh_rise", 1'b1, 1'b0, 1'b0, 16'd0);
    delay = 16'd0;
    step_chk("rh_on2", 1'b1, 1'b0, 1'b0, 16'd0);
    enable = 1'b0;
    step_chk("rh_fall", 1'b0, 1'b0, 1'b1, 16'd0);

    // Maximum delay on the 4-bit instance: 15 hold cycles, no wrap.
    delay  = 16'd15;
    enable = 1'b1;
    step_chk("mx_on", 1'b1, 1'b0, 1'b0, 16'd0);
    enable = 1'b0;
    for (int i = 15; i >= 1; i--) begin
      step_chk("mx_hold", 1'b1, 1'b1, 1'b0, 16'(i));
      check_eq("w4_cnt", 32'(cnt_w4), 32'(i));
      check_eq("w4_ha",  32'(ha_w4),  32'd1);
      check_eq("w4_de",  32'(de_w4),  32'd1);
    end
    step_chk("mx_fall", 1'b0, 1'b0, 1'b1, 16'd0);
    check_eq("w4_fall_de",  32'(de_w4),  32'd0);
    check_eq("w4_fall_hd",  32'(hd_w4),  32'd1);
    check_eq("w4_fall_cnt", 32'(cnt_w4), 32'd0);
    step_chk("mx_idle", 1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("w4_idle_cnt", 32'(cnt_w4), 32'd0);
    check_eq("w4_idle_hd",  32'(hd_w4),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
